// File: rtl/vga_scan_driver.sv
// vga_scan_driver
//   Generates VGA 640x480@60 timing from a 100 MHz clock using a free-running
//   divide-by-4 pixel enable, exposes the current visible coordinate to the
//   compositor, and registers the compositor colour plus sync/blank signals
//   so they leave the block aligned with each other.
//
// Ports
//   clk          system clock (100 MHz), the only clock
//   rst          asynchronous active-high reset
//   color        12-bit pixel colour from the compositor, {R,G,B} 4 bits each
//   x, y         current visible column/row (0 outside the active region)
//   hs, vs       horizontal/vertical sync, active low, registered
//   r, g, b      registered colour outputs, forced to 0 outside active video
//   rdn          display-active, active low, aligned with r/g/b
//   frame_start  one-clk pulse when the counters wrap to the top-left corner
module vga_scan_driver #(
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int H_VIS   = 640,
  parameter int H_TOTAL = 800,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33,
  parameter int V_VIS   = 480,
  parameter int V_TOTAL = 525
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] color,
  output logic [9:0]  x,
  output logic [8:0]  y,
  output logic        hs,
  output logic        vs,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic        rdn,
  output logic        frame_start
);

  // Timing boundaries sized to the 10-bit counters so every compare is
  // width-matched.
  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_END  = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_END  = 10'(V_SYNC);
  localparam logic [9:0] H_ACT_BEG   = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_ACT_END   = 10'(H_SYNC + H_BACK + H_VIS);
  localparam logic [9:0] V_ACT_BEG   = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_ACT_END   = 10'(V_SYNC + V_BACK + V_VIS);

  logic [1:0]  presc_q, presc_d;
  logic [9:0]  h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic        frame_start_q, frame_start_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        rdn_q, rdn_d;
  logic [11:0] rgb_q, rgb_d;

  logic pix_en;
  logic hsync_raw;
  logic vsync_raw;
  logic active;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q       <= 2'd0;
      h_cnt_q       <= 10'd0;
      v_cnt_q       <= 10'd0;
      frame_start_q <= 1'b0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      rdn_q         <= 1'b1;
      rgb_q         <= 12'h000;
    end else begin
      presc_q       <= presc_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      frame_start_q <= frame_start_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      rdn_q         <= rdn_d;
      rgb_q         <= rgb_d;
    end
  end

  // Pixel-rate scan counters. frame_start is registered so its single-clk
  // pulse coincides with the counters sitting at (0,0).
  always_comb begin
    presc_d       = presc_q + 2'd1;
    pix_en        = (presc_q == 2'd3);
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    frame_start_d = 1'b0;
    if (pix_en) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = 10'd0;
        if (v_cnt_q == V_LAST) begin
          v_cnt_d       = 10'd0;
          frame_start_d = 1'b1;
        end else begin
          v_cnt_d = v_cnt_q + 10'd1;
        end
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
  end

  // Raw timing decode and coordinates. x/y are combinational so the
  // compositor has a full pixel period to produce color before it is latched.
  always_comb begin
    hsync_raw = (h_cnt_q >= H_SYNC_END);
    vsync_raw = (v_cnt_q >= V_SYNC_END);
    active    = (h_cnt_q >= H_ACT_BEG) && (h_cnt_q < H_ACT_END) &&
                (v_cnt_q >= V_ACT_BEG) && (v_cnt_q < V_ACT_END);
    x = 10'd0;
    y = 9'd0;
    if (active) begin
      x = h_cnt_q - H_ACT_BEG;
      y = 9'(v_cnt_q - V_ACT_BEG);
    end
  end

  // Output stage: colour and sync share one pixel of latency. The colour
  // mux selects a constant outside active video so an undefined color input
  // there never reaches the pins.
  always_comb begin
    hs_d  = hs_q;
    vs_d  = vs_q;
    rdn_d = rdn_q;
    rgb_d = rgb_q;
    if (pix_en) begin
      hs_d  = hsync_raw;
      vs_d  = vsync_raw;
      rdn_d = ~active;
      if (active) begin
        rgb_d = color;
      end else begin
        rgb_d = 12'h000;
      end
    end
  end

  assign hs          = hs_q;
  assign vs          = vs_q;
  assign rdn         = rdn_q;
  assign r           = rgb_q[11:8];
  assign g           = rgb_q[7:4];
  assign b           = rgb_q[3:0];
  assign frame_start = frame_start_q;

endmodule

// File: doc/vga_scan_driver.md
VGA_SCAN_DRIVER -- requirements
Module: vga_scan_driver

Interface
REQ-001 Parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-002 Parameter H_BACK, default 48, horizontal back porch in pixels.
REQ-003 Parameter H_VIS, default 640, visible pixels per line.
REQ-004 Parameter H_TOTAL, default 800, pixels per line.
REQ-005 Parameter V_SYNC, default 2, vertical sync width in lines.
REQ-006 Parameter V_BACK, default 33, vertical back porch in lines.
REQ-007 Parameter V_VIS, default 480, visible lines per frame.
REQ-008 Parameter V_TOTAL, default 525, lines per frame.
REQ-009 Port clk, input, 1: system clock, 100 MHz; the only clock.
REQ-010 Port rst, input, 1: reset; asynchronous and active-high.
REQ-011 Port color, input, 12: pixel colour from the background/sprite compositor; [11:8] R, [7:4] G, [3:0] B.
REQ-012 Port x, output, 10: current visible column, 0..639.
REQ-013 Port y, output, 9: current visible row, 0..479.
REQ-014 Port hs, output, 1: horizontal sync, active low.
REQ-015 Port vs, output, 1: vertical sync, active low.
REQ-016 Ports r, g, b, output, 4 each: VGA colour outputs.
REQ-017 Port rdn, output, 1: display-active, active low, aligned with r/g/b.
REQ-018 Port frame_start, output, 1: one-clk pulse at the start of each frame.

Function
REQ-019 A 2-bit prescaler runs free on clk; pix_en is asserted for one clk when the prescaler equals 3 (one pixel tick every 4 clk, 25 MHz).
REQ-020 h_cnt (10 bits) increments on pix_en; at H_TOTAL-1 it wraps to 0 and v_cnt increments on the same tick.
REQ-021 v_cnt (10 bits) wraps from V_TOTAL-1 to 0 on the same tick in which h_cnt wraps.
REQ-022 The tick in which both counters wrap to 0 pulses frame_start for exactly one clk.
REQ-023 Raw hsync is low while h_cnt < H_SYNC; raw vsync is low while v_cnt < V_SYNC.
REQ-024 The active region is H_SYNC+H_BACK <= h_cnt < H_SYNC+H_BACK+H_VIS (144..783) and V_SYNC+V_BACK <= v_cnt < V_SYNC+V_BACK+V_VIS (35..514).
REQ-025 Inside the active region, x = h_cnt-144 and y = v_cnt-35; outside it, x and y are 0.
REQ-026 x and y are combinational from the counters, so the compositor sees them one full pixel period (4 clk) before sampling.
REQ-027 Output stage: on pix_en, color is registered into r/g/b, and raw hsync, raw vsync and active are registered into hs, vs and rdn (rdn = ~active); these outputs share one pixel of latency.
REQ-028 Outside the active region, r/g/b are registered as 0 regardless of color.
REQ-029 hs and vs change only on pix_en ticks; the hs low pulse lasts exactly 96 pixels (384 clk), and the vs low pulse lasts exactly 2 lines (1600 pixels).
REQ-030 The frame period is exactly 420000 pixels (1680000 clk); frame_start period is the same.
REQ-031 color is treated as don't-care while rdn is high; X on color then causes no X on r/g/b.

Reset
REQ-032 While rst is high: prescaler, h_cnt and v_cnt are 0; hs=1, vs=1, rdn=1, r=g=b=0, frame_start=0.
REQ-033 Reset acts immediately, without waiting for clk, including mid-line or mid-frame; after release, counting restarts at h_cnt=0, v_cnt=0, and the first pix_en occurs on the 4th rising clk edge.
REQ-034 The tick that wraps the counters to (0,0) after reset release pulses frame_start; the release itself produces no pulse.

Verification
REQ-035 Release reset and count clk between successive hs falling edges -> 3200; hs low width -> 384 clk.
REQ-036 Measure vs across one frame -> low for 6400 clk; period 1680000 clk; frame_start pulses once per frame, one clk wide.
REQ-037 Drive color = x[3:0]-based stripe; sample r/g/b when rdn falls -> values equal color for x=0; the last active pixel corresponds to x=639; y spans 0..479.
REQ-038 Hold color=12'hFFF constantly -> r/g/b are 0 whenever rdn=1 (porches, sync); 4'hF whenever rdn=0.
REQ-039 Assert rst at h_cnt=400, v_cnt=200 for 3 clk -> outputs reach reset values asynchronously; after release, first hs falling edge follows within 4 clk, and frame timing matches REQ-035.
REQ-040 Drive color = X while rdn=1 -> no X on r/g/b, hs, vs or rdn.
